// File: rtl/bip_program_loader_pkg.sv
// Shared BIP definitions for the program loader: widths, FSM encoding and clogb2.
package bip_program_loader_pkg;

    localparam int unsigned BIP_NB_BITS       = 16;
    localparam int unsigned BIP_INS_MEM_DEPTH = 2048;
    localparam int unsigned BIP_LEN_BITS      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DAT_LO = 3'd3,
        ST_DAT_HI = 3'd4,
        ST_WRITE  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } loader_state_t;

    // Number of bits needed to represent value (at least 1).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned r_bits;
        int unsigned r_val;
        r_bits = 0;
        r_val  = value;
        while (r_val > 0) begin
            r_bits++;
            r_val = r_val >> 1;
        end
        if (r_bits == 0) begin
            r_bits = 1;
        end
        return r_bits;
    endfunction

endpackage

// File: rtl/bip_program_loader_if.sv
// Byte-stream input and program-memory write port of the BIP program loader.
interface bip_program_loader_if
    import bip_program_loader_pkg::*;
#(
    parameter int unsigned NB_BITS = BIP_NB_BITS,
    parameter int unsigned NB_ADDR = clogb2(BIP_INS_MEM_DEPTH - 1)
);

    logic [7:0]         i_data;
    logic               i_valid;
    logic               o_ready;
    logic [NB_ADDR-1:0] o_addr;
    logic [NB_BITS-1:0] o_data;
    logic               o_wr;

    // Loader side: consumes bytes, drives the memory write port.
    modport master (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_addr,
        output o_data,
        output o_wr
    );

    // Host/memory side: produces bytes, receives writes.
    modport slave (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_addr,
        input  o_data,
        input  o_wr
    );

endinterface

// File: rtl/bip_program_loader_byte_assembler.sv
// Pairs a stored low byte with the current high byte into a 16-bit value and an NB_BITS word.
module bip_byte_assembler
    import bip_program_loader_pkg::*;
#(
    parameter int unsigned NB_BITS = BIP_NB_BITS
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_byte,
    input  logic               i_ld_lo,
    output logic [15:0]        o_pair,
    output logic [NB_BITS-1:0] o_word
);

    logic [7:0] r_lo;

    // Capture the low byte of each length/data pair when it is accepted.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_lo <= '0;
        end else if (i_ld_lo) begin
            r_lo <= i_byte;
        end
    end

    // High byte is taken straight from the stream so the pair is usable on acceptance.
    always_comb begin
        o_pair = {i_byte, r_lo};
        o_word = NB_BITS'(o_pair);
    end

endmodule

// File: rtl/bip_program_loader.sv
// BIP program loader: receives a length-prefixed byte frame, writes words into
// program memory and holds the CPU in reset while a download is in progress.
module bip_program_loader
    import bip_program_loader_pkg::*;
#(
    parameter int unsigned NB_BITS       = BIP_NB_BITS,
    parameter int unsigned INS_MEM_DEPTH = BIP_INS_MEM_DEPTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    output logic                    o_cpu_run,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    bip_program_loader_if.master    bus
);

    localparam int unsigned NB_ADDR = clogb2(INS_MEM_DEPTH - 1);

    loader_state_t          r_state;
    loader_state_t          w_state_next;

    logic [BIP_LEN_BITS-1:0] r_len;
    logic [NB_ADDR-1:0]      r_idx;
    logic [NB_ADDR-1:0]      r_addr;
    logic [NB_BITS-1:0]      r_data;

    logic [15:0]             w_pair;
    logic [NB_BITS-1:0]      w_word;
    logic                    w_accept;
    logic                    w_ld_lo;
    logic                    w_last;
    logic                    w_len_over;

    logic                    w_ready;
    logic                    w_wr;
    logic                    w_cpu_run;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_error;

    bip_byte_assembler #(
        .NB_BITS (NB_BITS)
    ) u_byte_assembler (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_byte  (bus.i_data),
        .i_ld_lo (w_ld_lo),
        .o_pair  (w_pair),
        .o_word  (w_word)
    );

    // Handshake and frame-position decode shared by the FSM and datapath.
    always_comb begin
        w_accept   = bus.i_valid & w_ready;
        w_ld_lo    = w_accept & ((r_state == ST_LEN_LO) | (r_state == ST_DAT_LO));
        w_last     = ((32'(r_idx) + 32'd1) == 32'(r_len));
        w_len_over = (32'(w_pair) > INS_MEM_DEPTH);
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and Moore output decode; o_error is sticky because ERR is only left via i_start.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_wr         = 1'b0;
        w_cpu_run    = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_error      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cpu_run = 1'b1;
                if (i_start) begin
                    w_state_next = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (bus.i_valid) begin
                    w_state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (bus.i_valid) begin
                    if (w_pair == 16'd0) begin
                        w_state_next = ST_DONE;
                    end else if (w_len_over) begin
                        w_state_next = ST_ERR;
                    end else begin
                        w_state_next = ST_DAT_LO;
                    end
                end
            end
            ST_DAT_LO: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (bus.i_valid) begin
                    w_state_next = ST_DAT_HI;
                end
            end
            ST_DAT_HI: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (bus.i_valid) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_wr   = 1'b1;
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_DAT_LO;
                end
            end
            ST_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            ST_ERR: begin
                w_error = 1'b1;
                if (i_start) begin
                    w_state_next = ST_LEN_LO;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Length latch, word index and write-port registers; the index stops at N-1 so it never wraps.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_len  <= '0;
            r_idx  <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            if ((r_state == ST_LEN_HI) && w_accept) begin
                r_len <= w_pair;
                r_idx <= '0;
            end
            if ((r_state == ST_DAT_HI) && w_accept) begin
                r_addr <= r_idx;
                r_data <= w_word;
            end
            if ((r_state == ST_WRITE) && !w_last) begin
                r_idx <= r_idx + NB_ADDR'(1);
            end
        end
    end

    // Drive the interface and status outputs.
    always_comb begin
        bus.o_ready = w_ready;
        bus.o_wr    = w_wr;
        bus.o_addr  = r_addr;
        bus.o_data  = r_data;
        o_cpu_run   = w_cpu_run;
        o_busy      = w_busy;
        o_done      = w_done;
        o_error     = w_error;
    end

endmodule

// File: tb/tb_bip_program_loader.sv
// Directed self-checking bench for bip_program_loader.
module tb_bip_program_loader;
    import bip_program_loader_pkg::*;

    logic i_clk;
    logic i_rst;
    logic i_start;
    logic o_cpu_run;
    logic o_busy;
    logic o_done;
    logic o_error;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned n_done;
    logic [26:0] wq[$];

    bip_program_loader_if #(.NB_BITS(16), .NB_ADDR(11)) u_if ();

    bip_program_loader #(
        .NB_BITS       (16),
        .INS_MEM_DEPTH (2048)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .o_cpu_run (o_cpu_run),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_error   (o_error),
        .bus       (u_if)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Record every memory write and done pulse, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (u_if.o_wr) wq.push_back({u_if.o_addr, u_if.o_data});
        if (o_done) n_done++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] wr_at(input int unsigned idx);
        if (idx < wq.size()) return wq[idx];
        return '1;
    endfunction

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Present one byte after gap idle cycles; optionally hold i_start high meanwhile.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap, input bit with_start);
        bit ok;
        u_if.i_valid = 1'b0;
        u_if.i_data  = 8'hFF;
        if (with_start) i_start = 1'b1;
        repeat (gap) @(negedge i_clk);
        u_if.i_data  = b;
        u_if.i_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (u_if.o_ready) begin
                ok = 1'b1;
                @(posedge i_clk);
                break;
            end
            @(negedge i_clk);
        end
        if (!ok) check_eq("byte_accept_timeout", 32'd0, 32'd1);
        @(negedge i_clk);
        u_if.i_valid = 1'b0;
        i_start      = 1'b0;
    endtask

    // Wait for the done pulse, then confirm the CPU is released the next cycle.
    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (o_done) begin
                ok = 1'b1;
                check_eq({tag, "_run_at_done"}, 32'(o_cpu_run), 32'd0);
                @(negedge i_clk);
                check_eq({tag, "_run_after"}, 32'(o_cpu_run), 32'd1);
                check_eq({tag, "_busy_after"}, 32'(o_busy), 32'd0);
                break;
            end
            @(negedge i_clk);
        end
        if (!ok) check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int unsigned dbase;
        logic [7:0] frame [6];
        n_vec = 0;
        n_err = 0;
        n_done = 0;
        i_rst = 1'b0;
        i_start = 1'b0;
        u_if.i_valid = 1'b0;
        u_if.i_data = 8'h00;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;

        // Reset and idle.
        repeat (10) @(negedge i_clk);
        check_eq("idle_cpu_run", 32'(o_cpu_run), 32'd1);
        check_eq("idle_ready", 32'(u_if.o_ready), 32'd0);
        check_eq("idle_wr_count", wq.size(), 32'd0);
        check_eq("idle_busy", 32'(o_busy), 32'd0);
        check_eq("idle_done_count", n_done, 32'd0);
        check_eq("idle_error", 32'(o_error), 32'd0);
        check_eq("idle_addr", 32'(u_if.o_addr), 32'd0);
        check_eq("idle_data", 32'(u_if.o_data), 32'd0);

        // Two-word frame.
        base = wq.size();
        dbase = n_done;
        pulse_start();
        check_eq("start_cpu_run", 32'(o_cpu_run), 32'd0);
        check_eq("start_busy", 32'(o_busy), 32'd1);
        check_eq("start_ready", 32'(u_if.o_ready), 32'd1);
        frame = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
        for (int i = 0; i < 6; i++) send_byte(frame[i], 0, 1'b0);
        wait_done("f2");
        check_eq("f2_wr_count", wq.size() - base, 32'd2);
        check_eq("f2_w0", 32'(wr_at(base)), 32'({11'd0, 16'h1234}));
        check_eq("f2_w1", 32'(wr_at(base + 1)), 32'({11'd1, 16'hABCD}));
        check_eq("f2_done_count", n_done - dbase, 32'd1);
        repeat (2) @(negedge i_clk);
        check_eq("f2_addr_hold", 32'(u_if.o_addr), 32'd1);
        check_eq("f2_data_hold", 32'(u_if.o_data), 32'hABCD);

        // Zero-length frame.
        base = wq.size();
        dbase = n_done;
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        check_eq("n0_done_now", 32'(o_done), 32'd1);
        wait_done("n0");
        check_eq("n0_wr_count", wq.size() - base, 32'd0);
        check_eq("n0_done_count", n_done - dbase, 32'd1);

        // Over-length frame (N = 2049), then recovery.
        base = wq.size();
        dbase = n_done;
        pulse_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h08, 0, 1'b0);
        check_eq("err_error", 32'(o_error), 32'd1);
        check_eq("err_cpu_run", 32'(o_cpu_run), 32'd0);
        check_eq("err_ready", 32'(u_if.o_ready), 32'd0);
        check_eq("err_busy", 32'(o_busy), 32'd0);
        repeat (5) @(negedge i_clk);
        check_eq("err_sticky", 32'(o_error), 32'd1);
        check_eq("err_cpu_held", 32'(o_cpu_run), 32'd0);
        check_eq("err_wr_count", wq.size() - base, 32'd0);
        check_eq("err_done_count", n_done - dbase, 32'd0);
        pulse_start();
        check_eq("err_cleared", 32'(o_error), 32'd0);
        check_eq("err_restart_busy", 32'(o_busy), 32'd1);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hEF, 0, 1'b0);
        send_byte(8'hBE, 0, 1'b0);
        wait_done("rec");
        check_eq("rec_w0", 32'(wr_at(base)), 32'({11'd0, 16'hBEEF}));

        // Gapped stream with i_start asserted mid-frame.
        base = wq.size();
        dbase = n_done;
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(frame[i], $urandom_range(0, 5), (i % 2) == 1);
        wait_done("gap");
        check_eq("gap_wr_count", wq.size() - base, 32'd2);
        check_eq("gap_w0", 32'(wr_at(base)), 32'({11'd0, 16'h1234}));
        check_eq("gap_w1", 32'(wr_at(base + 1)), 32'({11'd1, 16'hABCD}));
        check_eq("gap_done_count", n_done - dbase, 32'd1);

        // Reset after the first word of a three-word frame.
        base = wq.size();
        pulse_start();
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        repeat (5) @(negedge i_clk);
        check_eq("rst_wr_count", wq.size() - base, 32'd1);
        check_eq("rst_w0", 32'(wr_at(base)), 32'({11'd0, 16'h1111}));
        check_eq("rst_cpu_run", 32'(o_cpu_run), 32'd1);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_addr", 32'(u_if.o_addr), 32'd0);
        check_eq("rst_data", 32'(u_if.o_data), 32'd0);

        // Fresh one-word frame after reset.
        base = wq.size();
        pulse_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h55, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        wait_done("post");
        check_eq("post_w0", 32'(wr_at(base)), 32'({11'd0, 16'hAA55}));
        check_eq("post_wr_count", wq.size() - base, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bip_program_loader.md
BIP_PROGRAM_LOADER -- requirements
Module: bip_program_loader

Interface
REQ-001 Parameter NB_BITS, default 16, instruction word width.
REQ-002 Parameter INS_MEM_DEPTH, default 2048, program memory depth in words.
REQ-003 Localparam NB_ADDR = clogb2(INS_MEM_DEPTH-1), 11 at default, program memory address width.
REQ-004 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-low.
REQ-006 i_start  input  1  one-cycle pulse; requests a new program download.
REQ-007 i_data  input  8  byte-stream data.
REQ-008 i_valid  input  1  i_data valid this cycle.
REQ-009 o_ready  output  1  loader accepts i_data this cycle.
REQ-010 o_addr  output  NB_ADDR  program memory write address.
REQ-011 o_data  output  NB_BITS  program memory write data.
REQ-012 o_wr  output  1  program memory write strobe.
REQ-013 o_cpu_run  output  1  1 = CPU released; 0 = CPU held in reset.
REQ-014 o_busy  output  1  download in progress.
REQ-015 o_done  output  1  one-cycle pulse on successful download completion.
REQ-016 o_error  output  1  sticky length error; cleared by the next accepted i_start or by reset.

Function
REQ-017 A byte SHALL be accepted only in a cycle where i_valid and o_ready are both 1.
REQ-018 States SHALL be IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, WRITE, DONE, ERR.
REQ-019 In IDLE, o_cpu_run=1 and o_ready=0; i_start moves the FSM to LEN_LO, clears o_error, and drops o_cpu_run in the next cycle.
REQ-020 The frame SHALL be a 16-bit word count N (low byte, then high byte) followed by N words, each sent low byte first.
REQ-021 LEN_LO/LEN_HI, DAT_LO/DAT_HI SHALL hold o_ready=1, advance only on an accepted byte, and wait indefinitely otherwise.
REQ-022 On LEN_HI acceptance: if N=0, go to DONE; if N>INS_MEM_DEPTH, go to ERR; otherwise go to DAT_LO with word index 0.
REQ-023 On DAT_HI acceptance, go to WRITE; in WRITE, o_wr=1 for exactly one cycle with o_addr = word index and o_data = {high byte, low byte}; o_ready=0.
REQ-024 After WRITE, increment the word index; if index = N, go to DONE, else go to DAT_LO.
REQ-025 DONE SHALL last one cycle with o_done=1, then return to IDLE (o_cpu_run=1 from the following cycle).
REQ-026 ERR SHALL assert o_error, hold o_cpu_run=0 and o_ready=0, and leave only on i_start (-> LEN_LO).
REQ-027 i_start SHALL be ignored in every state except IDLE and ERR.
REQ-028 o_busy SHALL be 1 in LEN_LO, LEN_HI, DAT_LO, DAT_HI, WRITE and DONE, and 0 otherwise.
REQ-029 o_wr SHALL never assert outside WRITE; the word index never reaches INS_MEM_DEPTH (no wrap-around).
REQ-030 o_addr/o_data SHALL hold their last values when o_wr=0.

Reset
REQ-031 When i_rst=0 at a clock edge: state=IDLE, o_cpu_run=1, o_ready=0, o_wr=0, o_busy=0, o_done=0, o_error=0, o_addr=0, o_data=0, internal counters 0.
REQ-032 Reset mid-download SHALL abandon the frame without further writes; words already written remain in memory.

Structure
REQ-033 FSM state encodings and the clogb2 function SHALL live in the shared BIP package; NB_BITS and INS_MEM_DEPTH defaults SHALL match the BIP top.
REQ-034 One sub-module is natural: bip_byte_assembler (low/high byte pairing into an NB_BITS word); the rest is flat.
REQ-035 At integration, o_addr/o_data/o_wr drive a write port on Program_Memory and o_cpu_run drives the CPU reset.

Verification
REQ-036 Reset, idle 10 cycles -> o_cpu_run=1, o_wr never asserts, all other outputs 0.
REQ-037 i_start; bytes 02 00 34 12 CD AB -> writes addr0=0x1234 then addr1=0xABCD, one o_done pulse, o_cpu_run=1 one cycle after DONE.
REQ-038 i_start; bytes 00 00 -> no o_wr, o_done pulses right after LEN_HI, o_cpu_run restored.
REQ-039 i_start; bytes 01 08 (N=2049) -> o_error=1, o_cpu_run stays 0, no writes; next i_start clears o_error.
REQ-040 Valid gaps of 0-5 random cycles between bytes, plus i_start pulses mid-frame -> identical write sequence, i_start ignored.
REQ-041 Reset asserted after first word of N=3 -> exactly one write seen, state IDLE, o_cpu_run=1 after reset.
